// File: rtl/ysyx_23060025_lsu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_lsu_pkg
// Shared constants for the load/store unit:
//   - RV32 funct3 encodings for loads and stores
//   - LSU FSM state encoding
//   - store_strb_base(): byte-enable pattern for an aligned store of a given
//     size, before shifting into the addressed lanes
// ---------------------------------------------------------------------------
package ysyx_23060025_lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_RADDR = 3'd1,
    LSU_RDATA = 3'd2,
    LSU_WRITE = 3'd3,
    LSU_WRESP = 3'd4,
    LSU_DONE  = 3'd5
  } lsu_state_e;

  // Unknown store sizes fall back to a full word.
  function automatic logic [3:0] store_strb_base(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_SB: store_strb_base = 4'b0001;
      FUNCT3_SH: store_strb_base = 4'b0011;
      default:   store_strb_base = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060025_lsu_align.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_lsu_align  (purely combinational)
// Load side : picks the byte/half/word out of the read beat using the
//             captured address offset and sign/zero-extends it.
// Store side: builds the write strobe and replicates the store data into
//             every lane so the addressed lanes carry the right bytes.
// Ports:
//   ld_offset_i/ld_type_i/rdata_i -> load_data_o
//   st_offset_i/st_type_i/store_data_i -> wstrb_o, wdata_o
// ---------------------------------------------------------------------------
module ysyx_23060025_lsu_align
  import ysyx_23060025_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [1:0]          ld_offset_i,
  input  logic [2:0]          ld_type_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  output logic [DATA_LEN-1:0] load_data_o,
  input  logic [1:0]          st_offset_i,
  input  logic [2:0]          st_type_i,
  input  logic [DATA_LEN-1:0] store_data_i,
  output logic [3:0]          wstrb_o,
  output logic [DATA_LEN-1:0] wdata_o
);

  logic [DATA_LEN-1:0] shifted;

  // Bring the addressed byte down to lane 0.
  assign shifted = rdata_i >> {ld_offset_i, 3'b000};

  always_comb begin
    case (ld_type_i)
      FUNCT3_LB:  load_data_o = {{(DATA_LEN-8){shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  load_data_o = {{(DATA_LEN-16){shifted[15]}}, shifted[15:0]};
      FUNCT3_LBU: load_data_o = {{(DATA_LEN-8){1'b0}}, shifted[7:0]};
      FUNCT3_LHU: load_data_o = {{(DATA_LEN-16){1'b0}}, shifted[15:0]};
      default:    load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    case (st_type_i)
      FUNCT3_SB: wdata_o = {(DATA_LEN/8){store_data_i[7:0]}};
      FUNCT3_SH: wdata_o = {(DATA_LEN/16){store_data_i[15:0]}};
      default:   wdata_o = store_data_i;
    endcase
  end

  assign wstrb_o = store_strb_base(st_type_i) << st_offset_i;

endmodule

// File: rtl/ysyx_23060025_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_lsu
// Load/store unit between EXU and WBU, mastering an AXI4-Lite bus.
//   EXU side : exu_valid_i / lsu_ready_o, op payload and pass-through fields
//   WBU side : lsu_valid_o / wbu_ready_i, reg_wdata_o and registered
//              pass-through outputs (wd_o, wreg_o, csr_*_o, ebreak_flag_o)
//   AXI side : AR/R channels for loads, AW/W/B channels for stores
// Clock `clock`, asynchronous active-low reset `reset`.
// ---------------------------------------------------------------------------
module ysyx_23060025_lsu
  import ysyx_23060025_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  // EXU -> LSU
  input  logic                exu_valid_i,
  output logic                lsu_ready_o,
  input  logic                mem_en_i,
  input  logic                mem_wen_i,
  input  logic [2:0]          mem_type_i,
  input  logic [ADDR_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] store_data_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic [2:0]          csr_type_i,
  input  logic [11:0]         csr_waddr_i,
  input  logic                ebreak_flag_i,
  // LSU -> WBU
  output logic                lsu_valid_o,
  input  logic                wbu_ready_i,
  output logic [DATA_LEN-1:0] reg_wdata_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic [2:0]          csr_type_o,
  output logic [11:0]         csr_waddr_o,
  output logic                ebreak_flag_o,
  // AXI4-Lite read
  output logic [ADDR_LEN-1:0] araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  // AXI4-Lite write
  output logic [ADDR_LEN-1:0] awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [3:0]          wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  lsu_state_e          state_q, state_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                lsu_valid_q, lsu_valid_d;

  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [2:0]          mem_type_q, mem_type_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [DATA_LEN-1:0] reg_wdata_q, reg_wdata_d;
  logic                wd_q, wd_d;
  logic [4:0]          wreg_q, wreg_d;
  logic [DATA_LEN-1:0] csr_wdata_q, csr_wdata_d;
  logic [2:0]          csr_type_q, csr_type_d;
  logic [11:0]         csr_waddr_q, csr_waddr_d;
  logic                ebreak_q, ebreak_d;

  logic                accept;
  logic                is_store;
  logic [DATA_LEN-1:0] load_data;
  logic [DATA_LEN-1:0] st_wdata;
  logic [3:0]          st_wstrb;
  logic                unused_resp;

  // Error responses are deliberately ignored; the access still completes.
  assign unused_resp = ^{rresp_i, bresp_i};

  // Ready is gated by reset so it reads 0 while reset is held and 1 in the
  // very first cycle after release, without waiting for a clock edge.
  assign lsu_ready_o = reset & (state_q == LSU_IDLE);
  assign accept      = exu_valid_i & lsu_ready_o;
  assign is_store    = mem_en_i & mem_wen_i;

  // Store lanes are built from the live inputs so they can be registered at
  // accept; load extension uses the captured address and type.
  ysyx_23060025_lsu_align #(
    .DATA_LEN(DATA_LEN)
  ) u_align (
    .ld_offset_i (addr_q[1:0]),
    .ld_type_i   (mem_type_q),
    .rdata_i     (rdata_i),
    .load_data_o (load_data),
    .st_offset_i (alu_result_i[1:0]),
    .st_type_i   (mem_type_i),
    .store_data_i(store_data_i),
    .wstrb_o     (st_wstrb),
    .wdata_o     (st_wdata)
  );

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    lsu_valid_d = lsu_valid_q;
    addr_d      = addr_q;
    mem_type_d  = mem_type_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    reg_wdata_d = reg_wdata_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    csr_wdata_d = csr_wdata_q;
    csr_type_d  = csr_type_q;
    csr_waddr_d = csr_waddr_q;
    ebreak_d    = ebreak_q;

    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          addr_d      = alu_result_i;
          mem_type_d  = mem_type_i;
          wdata_d     = is_store ? st_wdata : '0;
          wstrb_d     = is_store ? st_wstrb : 4'b0000;
          reg_wdata_d = DATA_LEN'(alu_result_i);
          wd_d        = wd_i & ~is_store;
          wreg_d      = wreg_i;
          csr_wdata_d = csr_wdata_i;
          csr_type_d  = csr_type_i;
          csr_waddr_d = csr_waddr_i;
          ebreak_d    = ebreak_flag_i;
          if (!mem_en_i) begin
            state_d     = LSU_DONE;
            lsu_valid_d = 1'b1;
          end else if (mem_wen_i) begin
            state_d   = LSU_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = LSU_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      LSU_RADDR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = LSU_RDATA;
        end
      end
      LSU_RDATA: begin
        if (rvalid_i) begin
          rready_d    = 1'b0;
          reg_wdata_d = load_data;
          lsu_valid_d = 1'b1;
          state_d     = LSU_DONE;
        end
      end
      LSU_WRITE: begin
        // AW and W retire independently; move on once neither is pending.
        awvalid_d = awvalid_q & ~awready_i;
        wvalid_d  = wvalid_q & ~wready_i;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = LSU_WRESP;
        end
      end
      LSU_WRESP: begin
        if (bvalid_i) begin
          bready_d    = 1'b0;
          lsu_valid_d = 1'b1;
          state_d     = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (wbu_ready_i) begin
          lsu_valid_d = 1'b0;
          state_d     = LSU_IDLE;
        end
      end
      default: begin
        state_d     = LSU_IDLE;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        lsu_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= LSU_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      lsu_valid_q <= 1'b0;
      addr_q      <= '0;
      mem_type_q  <= 3'b000;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      reg_wdata_q <= '0;
      wd_q        <= 1'b0;
      wreg_q      <= 5'd0;
      csr_wdata_q <= '0;
      csr_type_q  <= 3'b000;
      csr_waddr_q <= 12'h000;
      ebreak_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      lsu_valid_q <= lsu_valid_d;
      addr_q      <= addr_d;
      mem_type_q  <= mem_type_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      reg_wdata_q <= reg_wdata_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      csr_wdata_q <= csr_wdata_d;
      csr_type_q  <= csr_type_d;
      csr_waddr_q <= csr_waddr_d;
      ebreak_q    <= ebreak_d;
    end
  end

  assign arvalid_o     = arvalid_q;
  assign rready_o      = rready_q;
  assign awvalid_o     = awvalid_q;
  assign wvalid_o      = wvalid_q;
  assign bready_o      = bready_q;
  assign lsu_valid_o   = lsu_valid_q;
  assign araddr_o      = addr_q;
  assign awaddr_o      = addr_q;
  assign wdata_o       = wdata_q;
  assign wstrb_o       = wstrb_q;
  assign reg_wdata_o   = reg_wdata_q;
  assign wd_o          = wd_q;
  assign wreg_o        = wreg_q;
  assign csr_wdata_o   = csr_wdata_q;
  assign csr_type_o    = csr_type_q;
  assign csr_waddr_o   = csr_waddr_q;
  assign ebreak_flag_o = ebreak_q;

endmodule

// File: tb/tb_ysyx_23060025_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060025_lsu
// Table of directed ops (non-memory, loads, stores) run through a simple
// always-ready bus responder, plus hand-written sequences for split AW/W
// acceptance, WBU back-pressure and reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_ysyx_23060025_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        exu_valid_i, lsu_ready_o;
  logic        mem_en_i, mem_wen_i;
  logic [2:0]  mem_type_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] csr_wdata_i;
  logic [2:0]  csr_type_i;
  logic [11:0] csr_waddr_i;
  logic        ebreak_flag_i;
  logic        lsu_valid_o, wbu_ready_i;
  logic [31:0] reg_wdata_o;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] csr_wdata_o;
  logic [2:0]  csr_type_o;
  logic [11:0] csr_waddr_o;
  logic        ebreak_flag_o;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i, rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;

  int n_tests = 0;
  int n_fail  = 0;
  int aw_beats = 0;
  int w_beats  = 0;

  always #5 clock = ~clock;

  ysyx_23060025_lsu #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clock(clock), .reset(reset),
    .exu_valid_i(exu_valid_i), .lsu_ready_o(lsu_ready_o),
    .mem_en_i(mem_en_i), .mem_wen_i(mem_wen_i), .mem_type_i(mem_type_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .csr_wdata_i(csr_wdata_i),
    .csr_type_i(csr_type_i), .csr_waddr_i(csr_waddr_i), .ebreak_flag_i(ebreak_flag_i),
    .lsu_valid_o(lsu_valid_o), .wbu_ready_i(wbu_ready_i), .reg_wdata_o(reg_wdata_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .csr_wdata_o(csr_wdata_o), .csr_type_o(csr_type_o),
    .csr_waddr_o(csr_waddr_o), .ebreak_flag_o(ebreak_flag_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  // Count AW and W handshakes actually taken by the bus.
  always @(posedge clock) begin
    if (reset) begin
      if (awvalid_o && awready_i) aw_beats = aw_beats + 1;
      if (wvalid_o && wready_i)   w_beats  = w_beats + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  typedef struct {
    logic        mem_en;
    logic        wen;
    logic [2:0]  mtype;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        wd;
    logic [31:0] exp_reg;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_wd;
  } vec_t;

  vec_t vecs[12];

  task automatic clear_slave();
    arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
  endtask

  task automatic present(input logic en, input logic wen, input logic [2:0] mt,
                         input logic [31:0] addr, input logic [31:0] sd, input logic wd);
    exu_valid_i = 1; mem_en_i = en; mem_wen_i = wen; mem_type_i = mt;
    alu_result_i = addr; store_data_i = sd; wd_i = wd;
  endtask

  // Scramble payload inputs after accept so only captured values can pass.
  task automatic scramble();
    exu_valid_i = 0; alu_result_i = 32'hFFFF_FFFF; store_data_i = 32'h0;
    mem_type_i = 3'b111; wd_i = ~wd_i; wreg_i = 5'h1F; csr_wdata_i = 32'h0;
    csr_type_i = 3'b111; csr_waddr_i = 12'hFFF; ebreak_flag_i = ~ebreak_flag_i;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat = -1;
    bit done = 0;
    logic [31:0] seen_addr = 0;
    logic [31:0] seen_wdata = 0;
    logic [3:0]  seen_strb = 0;
    chk("ready_idle", {31'd0, lsu_ready_o}, 1);
    present(v.mem_en, v.wen, v.mtype, v.addr, v.sdata, v.wd);
    wreg_i = idx[4:0]; csr_wdata_i = 32'hC000_0000 | idx;
    csr_type_i = idx[2:0]; csr_waddr_i = 12'h300 + 12'(idx);
    ebreak_flag_i = idx[0]; wbu_ready_i = 1;
    @(negedge clock);
    scramble();
    for (int i = 0; i < 20 && !done; i++) begin
      if (lsu_valid_o) begin
        done = 1; lat = i;
      end else begin
        if (arvalid_o) seen_addr = araddr_o;
        if (awvalid_o) seen_addr = awaddr_o;
        if (wvalid_o) begin seen_strb = wstrb_o; seen_wdata = wdata_o; end
        arready_i = arvalid_o; awready_i = awvalid_o; wready_i = wvalid_o;
        rvalid_i = rready_o; rdata_i = v.rdata; rresp_i = v.resp;
        bvalid_i = bready_o; bresp_i = v.resp;
        @(negedge clock);
      end
    end
    clear_slave();
    $display("[TB] vec %0d en=%0b wen=%0b f3=%0d addr=%h reg_wdata=%h wstrb=%b wd=%0b lat=%0d",
             idx, v.mem_en, v.wen, v.mtype, v.addr, reg_wdata_o, wstrb_o, wd_o, lat);
    chk("done_seen", {31'd0, done}, 1);
    chk("reg_wdata", reg_wdata_o, v.exp_reg);
    chk("wd_o", {31'd0, wd_o}, {31'd0, v.exp_wd});
    chk("wstrb_o", {28'd0, wstrb_o}, {28'd0, v.exp_strb});
    chk("wreg_o", {27'd0, wreg_o}, idx);
    chk("csr_wdata_o", csr_wdata_o, 32'hC000_0000 | idx);
    chk("csr_waddr_o", {20'd0, csr_waddr_o}, 32'h300 + idx);
    chk("ebreak_o", {31'd0, ebreak_flag_o}, idx & 1);
    if (v.mem_en) chk("bus_addr", seen_addr, v.addr);
    if (v.mem_en && v.wen) begin
      chk("bus_wdata", seen_wdata, v.exp_wdata);
      chk("bus_wstrb", {28'd0, seen_strb}, {28'd0, v.exp_strb});
    end
    if (!v.mem_en) chk("nonmem_latency", lat, 0);
    @(negedge clock);
    chk("back_to_idle", {31'd0, lsu_valid_o}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    //          en   wen  f3      addr          sdata         rdata         rsp  wd   exp_reg       strb     exp_wdata     exp_wd
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        2'd0, 1'b1, 32'h0000_1234, 4'b0000, 32'h0,        1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_0000, 2'd0, 1'b1, 32'hFFFF_FF80, 4'b0000, 32'h0,        1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,        32'h80FF_0000, 2'd0, 1'b1, 32'h0000_0080, 4'b0000, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,        32'h80FF_0000, 2'd0, 1'b0, 32'hFFFF_80FF, 4'b0000, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0,        32'h1234_F00D, 2'd0, 1'b1, 32'h0000_F00D, 4'b0000, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 2'd0, 1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0,        32'h0000_7F00, 2'd0, 1'b1, 32'h0000_007F, 4'b0000, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0,        32'h0000_8001, 2'd2, 1'b1, 32'hFFFF_8001, 4'b0000, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0,        2'd0, 1'b1, 32'h8000_0002, 4'b1100, 32'hABCD_ABCD, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56EF, 32'h0,        2'd0, 1'b0, 32'h8000_0001, 4'b0010, 32'hEFEF_EFEF, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'hCAFE_BABE, 32'h0,        2'd0, 1'b1, 32'h8000_0000, 4'b1111, 32'hCAFE_BABE, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_0055, 32'h0,        2'd3, 1'b1, 32'h8000_0003, 4'b1000, 32'h5555_5555, 1'b0};

    reset = 0;
    exu_valid_i = 0; mem_en_i = 0; mem_wen_i = 0; mem_type_i = 0;
    alu_result_i = 0; store_data_i = 0; wd_i = 0; wreg_i = 0;
    csr_wdata_i = 0; csr_type_i = 0; csr_waddr_i = 0; ebreak_flag_i = 0;
    wbu_ready_i = 1;
    clear_slave();
    @(negedge clock);
    @(negedge clock);
    $display("[TB] reset state ready=%0b valid=%0b wstrb=%b", lsu_ready_o, lsu_valid_o, wstrb_o);
    chk("rst_ready", {31'd0, lsu_ready_o}, 0);
    chk("rst_valid", {31'd0, lsu_valid_o}, 0);
    chk("rst_bus", {26'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, 1'b0}, 0);
    chk("rst_wstrb", {28'd0, wstrb_o}, 0);
    chk("rst_reg_wdata", reg_wdata_o, 0);
    reset = 1;
    #1;

    // Vector 0 is accepted in the first cycle after reset release.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Store where AW is accepted two cycles ahead of W.
    begin
      int aw0, w0;
      aw0 = aw_beats; w0 = w_beats;
      present(1'b1, 1'b1, 3'b010, 32'h8000_0010, 32'h1122_3344, 1'b1);
      wbu_ready_i = 1;
      @(negedge clock);
      scramble();
      chk("split_both_valid", {30'd0, awvalid_o, wvalid_o}, 3);
      awready_i = 1;
      @(negedge clock);
      awready_i = 0;
      chk("split_aw_dropped", {30'd0, awvalid_o, wvalid_o}, 1);
      @(negedge clock);
      chk("split_w_held", {30'd0, wvalid_o, bready_o}, 2);
      wready_i = 1;
      @(negedge clock);
      wready_i = 0;
      chk("split_wresp", {29'd0, awvalid_o, wvalid_o, bready_o}, 1);
      chk("split_aw_beats", aw_beats - aw0, 1);
      chk("split_w_beats", w_beats - w0, 1);
      bvalid_i = 1;
      @(negedge clock);
      bvalid_i = 0;
      chk("split_done", {30'd0, lsu_valid_o, bready_o}, 2);
      chk("split_beats_final", (aw_beats - aw0) * 16 + (w_beats - w0), 17);
      $display("[TB] split store aw_beats=%0d w_beats=%0d valid=%0b", aw_beats - aw0, w_beats - w0, lsu_valid_o);
      @(negedge clock);
      chk("split_idle", {31'd0, lsu_ready_o}, 1);
    end

    // WBU back-pressure: result must hold while wbu_ready is low.
    present(1'b0, 1'b0, 3'b000, 32'hA5A5_0001, 32'h0, 1'b1);
    wreg_i = 5'd9;
    wbu_ready_i = 0;
    @(negedge clock);
    scramble();
    for (int k = 0; k < 3; k++) begin
      $display("[TB] hold cycle %0d valid=%0b ready=%0b reg_wdata=%h", k, lsu_valid_o, lsu_ready_o, reg_wdata_o);
      chk("hold_valid", {31'd0, lsu_valid_o}, 1);
      chk("hold_payload", reg_wdata_o, 32'hA5A5_0001);
      chk("hold_wreg", {27'd0, wreg_o}, 9);
      chk("hold_not_ready", {31'd0, lsu_ready_o}, 0);
      @(negedge clock);
    end
    chk("hold_valid_end", {31'd0, lsu_valid_o}, 1);
    wbu_ready_i = 1;
    @(negedge clock);
    chk("hold_release", {30'd0, lsu_valid_o, lsu_ready_o}, 1);

    // Reset pulse while waiting for read data.
    present(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 1'b1);
    wreg_i = 5'd3;
    @(negedge clock);
    scramble();
    arready_i = arvalid_o;
    @(negedge clock);
    arready_i = 0;
    chk("rst_mid_in_rdata", {31'd0, rready_o}, 1);
    reset = 0;
    #1;
    $display("[TB] mid reset ready=%0b valid=%0b rready=%0b araddr=%h", lsu_ready_o, lsu_valid_o, rready_o, araddr_o);
    chk("rst_mid_ready", {31'd0, lsu_ready_o}, 0);
    chk("rst_mid_valid", {31'd0, lsu_valid_o}, 0);
    chk("rst_mid_bus", {27'd0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
    chk("rst_mid_araddr", araddr_o, 0);
    chk("rst_mid_payload", {reg_wdata_o[26:0], wreg_o}, 0);
    rvalid_i = 1; rdata_i = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("rst_mid_no_valid", {30'd0, lsu_valid_o, rready_o}, 0);
    rvalid_i = 0; rdata_i = 0;
    reset = 1;
    #1;
    chk("post_rst_ready", {31'd0, lsu_ready_o}, 1);
    present(1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0, 1'b1);
    wbu_ready_i = 1;
    @(negedge clock);
    scramble();
    $display("[TB] post reset op valid=%0b reg_wdata=%h", lsu_valid_o, reg_wdata_o);
    chk("post_rst_valid", {31'd0, lsu_valid_o}, 1);
    chk("post_rst_data", reg_wdata_o, 32'h0000_0077);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
